// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Brief    : Round-robin arbiter and sequencer sharing one combinational
//            barrel shifter between two requesters (ALU path, address path).
//            Each op runs through one shifter pass (two for rotate), and the
//            result is returned on a response port tagged with the requester id.
// Options  : SHIFT_ARB_ROTATE_EN - when defined, ctrl 10 is a rotate left
//            built from a left pass and a right pass OR-combined; when
//            undefined, ctrl 10 behaves as pass-through and ROT2 is absent.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_ctrl,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_ctrl,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [WIDTH-1:0]   req1_data,
  output logic [1:0]         sh_ctrl,
  output logic [SHAMT_W-1:0] sh_shamt,
  output logic [WIDTH-1:0]   sh_data,
  input  logic [WIDTH-1:0]   sh_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_ROT2 = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  localparam logic [1:0] c_OP_PASS = 2'b00;
  localparam logic [1:0] c_OP_SLL  = 2'b01;
  localparam logic [1:0] c_OP_ROL  = 2'b10;
  localparam logic [1:0] c_OP_SRL  = 2'b11;

  logic [1:0]         state_q, state_d;
  logic               last_grant_q;
  logic [1:0]         op_ctrl_q;
  logic [SHAMT_W-1:0] op_shamt_q;
  logic [WIDTH-1:0]   op_data_q;
  logic               op_id_q;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               w_idle;
  logic               w_grant;
  logic               w_accept;
  logic [1:0]         w_sel_ctrl;
  logic [1:0]         w_lat_ctrl;
  logic [SHAMT_W-1:0] w_sel_shamt;
  logic [WIDTH-1:0]   w_sel_data;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  assign w_idle   = (state_q == c_IDLE);
  assign w_grant  = req0_valid ? (req1_valid ? ~last_grant_q : 1'b0) : 1'b1;
  // Ready is held low while reset is asserted so the outputs show reset values.
  assign req0_ready = w_idle & ~rst & req0_valid & ~w_grant;
  assign req1_ready = w_idle & ~rst & req1_valid &  w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_ctrl  = w_grant ? req1_ctrl  : req0_ctrl;
  assign w_sel_shamt = w_grant ? req1_shamt : req0_shamt;
  assign w_sel_data  = w_grant ? req1_data  : req0_data;

`ifdef SHIFT_ARB_ROTATE_EN
  assign w_lat_ctrl = w_sel_ctrl;
  // Second rotate pass shifts right by the complement amount; shamt is
  // nonzero in ROT2 so the result always fits in SHAMT_W bits.
  localparam logic [SHAMT_W:0] c_WIDTH_EXT = WIDTH[SHAMT_W:0];
  logic [SHAMT_W:0] w_rot_shamt;
  assign w_rot_shamt = c_WIDTH_EXT - {1'b0, op_shamt_q};
`else
  // Without rotate support, ctrl 10 collapses to a plain pass-through.
  assign w_lat_ctrl = (w_sel_ctrl == c_OP_ROL) ? c_OP_PASS : w_sel_ctrl;
`endif

  // State register plus latched operation, grant history and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_IDLE;
      last_grant_q <= 1'b1;
      op_ctrl_q    <= 2'b00;
      op_shamt_q   <= '0;
      op_data_q    <= '0;
      op_id_q      <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (w_accept) begin
        last_grant_q <= w_grant;
        op_ctrl_q    <= w_lat_ctrl;
        op_shamt_q   <= w_sel_shamt;
        op_data_q    <= w_sel_data;
        op_id_q      <= w_grant;
      end
    end
  end

  // Next-state and result accumulation.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) state_d = c_EXEC;
      end
      c_EXEC: begin
        res_d   = sh_result;
        state_d = c_RESP;
`ifdef SHIFT_ARB_ROTATE_EN
        if ((op_ctrl_q == c_OP_ROL) && (op_shamt_q != '0)) state_d = c_ROT2;
`endif
      end
`ifdef SHIFT_ARB_ROTATE_EN
      c_ROT2: begin
        res_d   = res_q | sh_result;
        state_d = c_RESP;
      end
`endif
      c_RESP: begin
        if (rsp_ready) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Shifter drive and response outputs decoded from the current state.
  always_comb begin
    sh_ctrl   = c_OP_PASS;
    sh_shamt  = '0;
    sh_data   = '0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    busy      = ~w_idle;
    case (state_q)
      c_EXEC: begin
        // Rotate's first pass is a left shift; the shifter never sees 10.
        sh_ctrl  = (op_ctrl_q == c_OP_ROL) ? c_OP_SLL : op_ctrl_q;
        sh_shamt = op_shamt_q;
        sh_data  = op_data_q;
      end
`ifdef SHIFT_ARB_ROTATE_EN
      c_ROT2: begin
        sh_ctrl  = c_OP_SRL;
        sh_shamt = w_rot_shamt[SHAMT_W-1:0];
        sh_data  = op_data_q;
      end
`endif
      c_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = op_id_q;
        rsp_data  = res_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Self-checking bench for shift_arbiter with a behavioural shifter
//            and a transaction-level reference model; honours
//            SHIFT_ARB_ROTATE_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req1_valid;
  wire                req0_ready, req1_ready;
  logic [1:0]         req0_ctrl, req1_ctrl;
  logic [SHAMT_W-1:0] req0_shamt, req1_shamt;
  logic [WIDTH-1:0]   req0_data, req1_data;
  wire  [1:0]         sh_ctrl;
  wire  [SHAMT_W-1:0] sh_shamt;
  wire  [WIDTH-1:0]   sh_data;
  logic [WIDTH-1:0]   sh_result;
  wire                rsp_valid;
  logic               rsp_ready;
  wire                rsp_id;
  wire  [WIDTH-1:0]   rsp_data;
  wire                busy;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_shamt(req0_shamt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_shamt(req1_shamt), .req1_data(req1_data),
    .sh_ctrl(sh_ctrl), .sh_shamt(sh_shamt), .sh_data(sh_data), .sh_result(sh_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural shifter; code 10 yields a poison value.
  always_comb begin
    case (sh_ctrl)
      2'b00:   sh_result = sh_data;
      2'b01:   sh_result = sh_data << sh_shamt;
      2'b11:   sh_result = sh_data >> sh_shamt;
      default: sh_result = 16'hDEAD;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference model state.
  bit          m_busy, m_resp, m_last, m_id, m_rot;
  int          m_wait, m_step;
  logic [3:0]  m_shamt;
  logic [15:0] m_data, m_res;
  bit          acc0, acc1;
  int          cyc = 0, acc_cyc = 0, rsp_cyc = 0;
  bit          rsp_seen;
  logic [15:0] last_data;
  bit          last_id;

  function automatic logic [15:0] ref_result(input logic [1:0] c, input logic [3:0] s,
                                             input logic [15:0] d);
    logic [31:0] dd;
    logic [15:0] r;
    case (c)
      2'b01:   r = d << s;
      2'b11:   r = d >> s;
`ifdef SHIFT_ARB_ROTATE_EN
      2'b10: begin
        dd = {d, d} << s;
        r  = dd[31:16];
      end
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit ref_rot_nz(input logic [1:0] c, input logic [3:0] s);
`ifdef SHIFT_ARB_ROTATE_EN
    return (c == 2'b10) && (s != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_last = 1; acc0 = 0; acc1 = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit g, any, obs_rv, obs_id;
    logic [15:0] obs_rd;
    #1;
    any = req0_valid | req1_valid;
    g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
    if (!m_busy) begin
      check("req0_ready", req0_ready, req0_valid && !g);
      check("req1_ready", req1_ready, req1_valid && g);
      check("busy_idle", busy, 0);
      check("rsp_valid_idle", rsp_valid, 0);
      check("sh_ctrl_idle", sh_ctrl, 0);
    end else begin
      check("req0_ready_busy", req0_ready, 0);
      check("req1_ready_busy", req1_ready, 0);
      check("busy", busy, 1);
      check("rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
        check("rsp_data", rsp_data, m_res);
        check("rsp_id", rsp_id, m_id);
      end else begin
        check("sh_data", sh_data, m_data);
        check("sh_shamt", sh_shamt, (m_step == 0) ? m_shamt : 4'(16 - int'(m_shamt)));
      end
    end
    check("sh_ctrl_not_10", sh_ctrl == 2'b10, 0);
    if (rsp_valid && !rsp_seen) begin rsp_seen = 1; rsp_cyc = cyc; end
    obs_rv = rsp_valid; obs_rd = rsp_data; obs_id = rsp_id;
    @(posedge clk);
    acc0 = 0; acc1 = 0;
    if (obs_rv && rsp_ready) begin last_data = obs_rd; last_id = obs_id; end
    if (!m_busy) begin
      if (any) begin
        acc0 = !g; acc1 = g;
        m_id = g; m_last = g;
        m_shamt = g ? req1_shamt : req0_shamt;
        m_data  = g ? req1_data : req0_data;
        m_res   = ref_result(g ? req1_ctrl : req0_ctrl, m_shamt, m_data);
        m_rot   = ref_rot_nz(g ? req1_ctrl : req0_ctrl, m_shamt);
        m_wait  = m_rot ? 2 : 1;
        m_step  = 0; m_busy = 1; m_resp = 0;
        acc_cyc = cyc; rsp_seen = 0;
      end
    end else if (!m_resp) begin
      m_step++; m_wait--;
      if (m_wait == 0) m_resp = 1;
    end else if (rsp_ready) begin
      m_busy = 0; m_resp = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic set0(input logic [1:0] c, input logic [3:0] s, input logic [15:0] d);
    req0_valid = 1; req0_ctrl = c; req0_shamt = s; req0_data = d;
  endtask

  task automatic set1(input logic [1:0] c, input logic [3:0] s, input logic [15:0] d);
    req1_valid = 1; req1_ctrl = c; req1_shamt = s; req1_data = d;
  endtask

  task automatic serve(input bit which);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = which ? acc1 : acc0;
    end
    check("accept_timeout", got, 1);
    if (which) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_busy; i++) cycle();
    check("drain_timeout", m_busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
    check({tag, "_sh_ctrl"}, sh_ctrl, 0);
    check({tag, "_sh_shamt"}, sh_shamt, 0);
    check({tag, "_sh_data"}, sh_data, 0);
  endtask

  initial begin
    int first;
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_ctrl = 0; req0_shamt = 0; req0_data = 0;
    req1_valid = 0; req1_ctrl = 0; req1_shamt = 0; req1_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1;
    #1;
    check_reset_outputs("reset");
    req0_valid = 0;
    rst = 0;

    // Tie straight after reset: req0 first, then req1; next tie goes to req0.
    set0(2'b11, 4'd1, 16'h8000);
    set1(2'b11, 4'd1, 16'h8000);
    first = -1;
    for (int i = 0; i < 30 && (req0_valid || req1_valid); i++) begin
      cycle();
      if (acc0) begin req0_valid = 0; if (first < 0) first = 0; end
      if (acc1) begin req1_valid = 0; if (first < 0) first = 1; end
    end
    check("tie_first", first, 0);
    check("tie_done", req0_valid || req1_valid, 0);
    drain();
    check("tie_last_id", last_id, 1);
    check("tie_last_data", last_data, 16'h4000);
    set0(2'b00, 4'd0, 16'h5555);
    set1(2'b00, 4'd0, 16'hAAAA);
    cycle();
    check("tie2_req0_wins", acc0, 1);
    req0_valid = 0;
    serve(1);
    drain();

    // Shift left logical, 2-cycle latency.
    set0(2'b01, 4'd4, 16'h00F1);
    serve(0);
    drain();
    check("sll_data", last_data, 16'h0F10);
    check("sll_id", last_id, 0);
    check("sll_latency", rsp_cyc - acc_cyc, 2);

    // Rotate by 4 and by 0.
    set1(2'b10, 4'd4, 16'hA00F);
    serve(1);
    drain();
`ifdef SHIFT_ARB_ROTATE_EN
    check("rol4_data", last_data, 16'h00FA);
    check("rol4_latency", rsp_cyc - acc_cyc, 3);
`else
    check("rol4_data", last_data, 16'hA00F);
    check("rol4_latency", rsp_cyc - acc_cyc, 2);
`endif
    check("rol4_id", last_id, 1);
    set1(2'b10, 4'd0, 16'h1234);
    serve(1);
    drain();
    check("rol0_data", last_data, 16'h1234);
    check("rol0_latency", rsp_cyc - acc_cyc, 2);

    // Back-pressure in RESP with req1 pending.
    rsp_ready = 0;
    set0(2'b01, 4'd1, 16'h0001);
    serve(0);
    set1(2'b11, 4'd2, 16'h0100);
    for (int i = 0; i < 10 && !m_resp; i++) cycle();
    check("hold_reached_resp", m_resp, 1);
    repeat (5) cycle();
    check("hold_no_accept", acc1, 0);
    rsp_ready = 1;
    cycle();
    check("hold_handshake_data", last_data, 16'h0002);
    cycle();
    check("hold_pending_accept", acc1, 1);
    req1_valid = 0;
    drain();
    check("hold_req1_data", last_data, 16'h0040);

    // Asynchronous reset while an op is in EXEC.
    set0(2'b01, 4'd3, 16'h0011);
    serve(0);
    set0(2'b11, 4'd4, 16'hF000);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("midop_reset");
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    serve(0);
    drain();
    check("after_reset_data", last_data, 16'h0F00);
    check("after_reset_latency", rsp_cyc - acc_cyc, 2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && ($urandom % 3 == 0))
        set0(2'($urandom), 4'($urandom), 16'($urandom));
      if (!req1_valid && ($urandom % 3 == 0))
        set1(2'($urandom), 4'($urandom), 16'($urandom));
      rsp_ready = ($urandom % 4) != 0;
      cycle();
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single 16-bit barrel shifter between two requesters (req0: ALU path, req1: address/immediate path).
- Round-robin arbitration with a valid/ready handshake on each request port.
- Sequences the shifter through one or two passes, registers the result and returns it on a response port tagged with the requester id.
- Sits between the decode/execute control and the shifter instance; the shifter itself stays combinational.

Parameters:
- WIDTH, 16, data width; must equal 2**SHAMT_W.
- SHAMT_W, 4, shift-amount width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_ctrl  input  2  op: 00 pass, 01 shift left logical, 11 shift right logical, 10 rotate left.
- req0_shamt  input  SHAMT_W  shift amount.
- req0_data  input  WIDTH  operand.
- req1_valid, req1_ready, req1_ctrl, req1_shamt, req1_data: same as req0, for requester 1.
- sh_ctrl  output  2  shiftControl to the shifter.
- sh_shamt  output  SHAMT_W  shamt to the shifter.
- sh_data  output  WIDTH  data to the shifter.
- sh_result  input  WIDTH  shifter output.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that issued the result.
- rsp_data  output  WIDTH  result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Single clock clk; rst is asynchronous, active-high. It clears all state immediately, including mid-operation; no response is produced for an aborted op.
- Reset values:
  - state = IDLE; last_grant = 1, so req0 wins the first tie.
  - req*_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - sh_ctrl = 00, sh_shamt = 0, sh_data = 0.
- FSM states: IDLE, EXEC, ROT2, RESP.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Grant rule: only one valid → that one. Both valid → the one not equal to last_grant.
  - On accept (valid & ready), latch ctrl/shamt/data/id, update last_grant, go to EXEC.
  - sh_ctrl is driven as 00 while idle.
- EXEC:
  - Drive the shifter from the latched op and capture sh_result into res.
  - ctrl 10 (rotate, feature enabled) with shamt != 0: drive sh_ctrl = 01, go to ROT2.
  - Otherwise go to RESP.
- ROT2:
  - Drive sh_ctrl = 11, sh_shamt = WIDTH - shamt (range 1..15, fits SHAMT_W), sh_data = latched data.
  - res <= res | sh_result; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data = res, rsp_id = latched id, both stable while rsp_valid is high.
  - Hold until rsp_ready. On rsp_valid & rsp_ready go to IDLE; a new accept is possible the next cycle.
- Latency from accept edge to rsp_valid:
  - 2 cycles for pass/shift and rotate by 0.
  - 3 cycles for rotate by nonzero.
- Throughput: one op per 3 cycles (4 for rotate) with rsp_ready tied high.
- The controller never drives sh_ctrl = 10 to the shifter; the shifter holds its output for that code.
- Requests that arrive while busy remain pending (no ready) and are arbitrated on return to IDLE.
- Width rules: all shifts are logical with zero fill; shamt = 0 returns data unchanged.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined: ctrl 10 performs rotate left as two shifter passes, OR-combined, as described above.
- Undefined: ctrl 10 is treated as 00 (pass-through, 2-cycle latency); the ROT2 state is not built.

Test Plan:
- req0 {01, 4, 16'h00F1}, rsp_ready = 1 → rsp_valid 2 cycles after accept; rsp_data = 16'h0F10, rsp_id = 0; sh_ctrl never shows 10.
- req0 and req1 both valid on the same cycle after reset, each {11, 1, 16'h8000} → req0 served first (rsp_id 0, data 16'h4000), then req1 (rsp_id 1); the next tie grants req0 again.
- With SHIFT_ARB_ROTATE_EN, req1 {10, 4, 16'hA00F} → sh_shamt shows 4 then 12; rsp_data = 16'h00FA after 3 cycles. With {10, 0, 16'h1234} → 16'h1234 after 2 cycles.
- Without the macro, {10, 4, 16'hA00F} → rsp_data = 16'hA00F after 2 cycles.
- rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_data, rsp_id stable; req*_ready stays 0; a pending req1 is accepted the cycle after the handshake.
- rst asserted during EXEC → all outputs return to reset values asynchronously; no rsp_valid follows; the first op after reset behaves normally.
